// File: rtl/coder_ip.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : coder_ip
// Brief    : K=3 (7,5) rate-1/2 convolutional encoder feeding a 4-state
//            hard-decision register-exchange Viterbi decoder.
// Revision : 1.0
// ============================================================================
module coder_ip #(
    parameter int DEPTH    = 8,
    parameter int METRIC_W = 5
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ip,
    output logic [1:0] op,
    output logic       viterbi_decoder_op
);

    localparam logic [METRIC_W-1:0] C_PM_INIT = METRIC_W'(8);

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic r_s1;
    logic r_s0;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_s1 <= 1'b0;
            r_s0 <= 1'b0;
            op   <= 2'b00;
        end else begin
            op   <= {ip ^ r_s1 ^ r_s0, ip ^ r_s0};
            r_s1 <= ip;
            r_s0 <= r_s1;
        end
    end

    // ------------------------------------------------------------------
    // Decoder: add-compare-select with register-exchange survivors
    // ------------------------------------------------------------------
    logic [1:0]          w_rx_sym;
    logic [METRIC_W-1:0] r_pm     [4];
    logic [DEPTH-1:0]    r_sp     [4];
    logic [METRIC_W-1:0] w_new_pm [4];
    logic [DEPTH-1:0]    w_new_sp [4];
    logic [1:0]          w_min_idx;
    logic [METRIC_W-1:0] w_min;
    logic [1:0]          w_best;

    assign w_rx_sym = op;

    function automatic logic [METRIC_W-1:0] branch_metric(
        input logic [1:0] rx,
        input logic [1:0] expected
    );
        logic [1:0] d;
        d = rx ^ expected;
        return METRIC_W'(d[1]) + METRIC_W'(d[0]);
    endfunction

    // Index of the smallest of four metrics; ties resolve to the lowest index.
    function automatic logic [1:0] argmin4(
        input logic [METRIC_W-1:0] m0,
        input logic [METRIC_W-1:0] m1,
        input logic [METRIC_W-1:0] m2,
        input logic [METRIC_W-1:0] m3
    );
        logic [1:0]          lo;
        logic [1:0]          hi;
        logic [METRIC_W-1:0] mlo;
        logic [METRIC_W-1:0] mhi;
        lo  = (m1 < m0) ? 2'd1 : 2'd0;
        mlo = (m1 < m0) ? m1 : m0;
        hi  = (m3 < m2) ? 2'd3 : 2'd2;
        mhi = (m3 < m2) ? m3 : m2;
        return (mhi < mlo) ? hi : lo;
    endfunction

    generate
        for (genvar i = 0; i < 4; i++) begin : g_acs
            // Next state {b,a}; predecessors {a,0} and {a,1} differ in both symbol bits.
            localparam int          A      = i % 2;
            localparam int          B      = i / 2;
            localparam logic [1:0]  C_EXP0 = {1'(B ^ A), 1'(B)};

            logic [METRIC_W-1:0] w_cand0;
            logic [METRIC_W-1:0] w_cand1;
            logic                w_sel;

            assign w_cand0     = r_pm[2*A]   + branch_metric(w_rx_sym, C_EXP0);
            assign w_cand1     = r_pm[2*A+1] + branch_metric(w_rx_sym, ~C_EXP0);
            assign w_sel       = (w_cand1 < w_cand0);
            assign w_new_pm[i] = w_sel ? w_cand1 : w_cand0;
            assign w_new_sp[i] = w_sel ? {r_sp[2*A+1][DEPTH-2:0], 1'(B)}
                                       : {r_sp[2*A][DEPTH-2:0],   1'(B)};
        end
    endgenerate

    assign w_min_idx = argmin4(w_new_pm[0], w_new_pm[1], w_new_pm[2], w_new_pm[3]);
    assign w_min     = w_new_pm[w_min_idx];
    assign w_best    = argmin4(r_pm[0], r_pm[1], r_pm[2], r_pm[3]);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int s = 0; s < 4; s++) begin
                r_pm[s] <= (s == 0) ? '0 : C_PM_INIT;
                r_sp[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 4; s++) begin
                r_pm[s] <= w_new_pm[s] - w_min;
                r_sp[s] <= w_new_sp[s];
            end
        end
    end

    assign viterbi_decoder_op = r_sp[w_best][DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_coder_ip.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_coder_ip
// Brief    : Self-checking bench for coder_ip (tables, directed and random).
// Revision : 1.0
// ============================================================================
module tb_coder_ip;

    localparam int DEPTH    = 8;
    localparam int METRIC_W = 5;
    localparam int N_ONES   = DEPTH + 8;

    typedef struct {
        logic       ip;
        logic [1:0] exp_op;
        logic       exp_dec;
    } vec_t;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       ip  = 1'b0;
    logic [1:0] op;
    logic       viterbi_decoder_op;

    int   n_vec = 0;
    int   n_err = 0;
    bit   hist[$];
    vec_t ones_tbl [N_ONES];
    logic [1:0] bad_sym;

    coder_ip #(
        .DEPTH    (DEPTH),
        .METRIC_W (METRIC_W)
    ) dut (
        .clk                (clk),
        .res                (res),
        .ip                 (ip),
        .op                 (op),
        .viterbi_decoder_op (viterbi_decoder_op)
    );

    always #5 clk = ~clk;

    // Bit sampled 'back' edges before the most recent one; zero before the stream began.
    function automatic bit past(input int back);
        int idx;
        idx = hist.size() - 1 - back;
        return (idx >= 0) ? hist[idx] : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: check outputs against the reference, then drive the next bit.
    task automatic check_model(input string tag);
        chk({tag, " op"}, op, {past(0) ^ past(1) ^ past(2), past(0) ^ past(2)});
        chk({tag, " dec"}, {1'b0, viterbi_decoder_op}, {1'b0, past(DEPTH)});
    endtask

    task automatic tick(input bit b, input string tag);
        check_model(tag);
        ip = b;
        hist.push_back(b);
        @(negedge clk);
    endtask

    task automatic tick_err(input bit b);
        logic [1:0] mask;
        check_model("err");
        ip = b;
        hist.push_back(b);
        mask    = 2'($urandom_range(1, 2));
        bad_sym = op ^ mask;
        force dut.w_rx_sym = bad_sym;
        @(posedge clk);
        #1;
        release dut.w_rx_sym;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        res = 1'b0;
        ip  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset op", op, 2'b00);
            chk("reset dec", {1'b0, viterbi_decoder_op}, 2'b00);
        end
        hist.delete();
        res = 1'b1;
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < N_ONES; k++) begin
            chk({tag, " op"}, op, ones_tbl[k].exp_op);
            chk({tag, " dec"}, {1'b0, viterbi_decoder_op}, {1'b0, ones_tbl[k].exp_dec});
            ip = ones_tbl[k].ip;
            hist.push_back(ones_tbl[k].ip);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] pat;
        logic [1:0]  pat_op [4];
        bit          b;

        // All-ones from reset, values read at each edge before it acts.
        for (int k = 0; k < N_ONES; k++) begin
            ones_tbl[k].ip      = 1'b1;
            ones_tbl[k].exp_op  = (k == 0) ? 2'b00 : (k == 1) ? 2'b11 : (k == 2) ? 2'b01 : 2'b10;
            ones_tbl[k].exp_dec = (k <= DEPTH) ? 1'b0 : 1'b1;
        end
        pat    = 16'b1101001100000000;
        pat_op = '{2'b11, 2'b01, 2'b01, 2'b00};

        @(negedge clk);

        apply_reset();
        repeat (40) tick(1'b0, "zeros");

        apply_reset();
        run_table("ones");

        @(posedge clk);
        #2;
        res = 1'b0;
        #1;
        chk("async op", op, 2'b00);
        chk("async dec", {1'b0, viterbi_decoder_op}, 2'b00);
        @(negedge clk);
        apply_reset();
        run_table("ones rerun");

        apply_reset();
        for (int k = 0; k < 64; k++) begin
            if (k >= 1 && k <= 4)
                chk("pattern head op", op, pat_op[k-1]);
            tick(pat[15 - (k % 16)], "pattern");
        end

        apply_reset();
        for (int k = 0; k < 240; k++) begin
            b = 1'($urandom);
            if (k >= 20 && (k % 15) == 0)
                tick_err(b);
            else
                tick(b, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
